// File: rtl/complex_dot_product_feeder.sv
// Initiator for the complex dot-product engine: fetches A/B vectors NI elements at a time,
// strobes each package into the engine, then returns the engine result on a valid/ready handshake.
module complex_dot_product_feeder #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NI            = 8,
  parameter int LEN_W         = 16,
  parameter int ADDR_W        = 16,
  parameter int PKT_GAP       = 8,
  parameter int RST_CYCLES    = 2,
  parameter int TIMEOUT       = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           a_base,
  input  logic [ADDR_W-1:0]           b_base,
  input  logic [LEN_W-1:0]            len,
  output logic                        busy,
  output logic                        mem_a_en,
  output logic [ADDR_W-1:0]           mem_a_addr,
  input  logic [ELEMENT_WIDTH-1:0]    mem_a_rdata,
  output logic                        mem_b_en,
  output logic [ADDR_W-1:0]           mem_b_addr,
  input  logic [ELEMENT_WIDTH-1:0]    mem_b_rdata,
  output logic                        dp_reset,
  output logic                        dp_read_now,
  output logic [ELEMENT_WIDTH*NI-1:0] dp_first_row,
  output logic [ELEMENT_WIDTH*NI-1:0] dp_second_row,
  input  logic                        dp_finish,
  input  logic [ELEMENT_WIDTH-1:0]    dp_result,
  output logic [ELEMENT_WIDTH-1:0]    result,
  output logic                        result_err,
  output logic                        result_valid,
  input  logic                        result_ready
);

  localparam int ROW_W   = ELEMENT_WIDTH * NI;
  localparam int CNT_MAX = TIMEOUT + NI + PKT_GAP + RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SLOT_W  = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_FETCH, S_ISSUE, S_GAP, S_WAIT_FIN, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [LEN_W:0]     pkt_base;
  logic [LEN_W:0]     elem_idx;
  logic [ADDR_W-1:0]  a_base_q, b_base_q;
  logic [LEN_W-1:0]   len_q;
  logic [ROW_W-1:0]   shadow_a, shadow_b, shadow_a_nx, shadow_b_nx;
  logic               fetch_issue, fetch_live, fetch_last, wait_timeout, more_pkts;
  logic               vld_p0, pad_p0;
  logic [SLOT_W-1:0]  slot_p0;

  assign elem_idx     = pkt_base + (LEN_W+1)'(cnt);
  assign fetch_issue  = (state == S_FETCH) && (cnt < CNT_W'(NI));
  assign fetch_live   = fetch_issue && (elem_idx < {1'b0, len_q});
  assign fetch_last   = (state == S_FETCH) && (cnt == CNT_W'(NI));
  assign wait_timeout = (cnt == CNT_W'(TIMEOUT - 1));
  assign more_pkts    = pkt_base < {1'b0, len_q};

  assign mem_a_en     = fetch_live;
  assign mem_b_en     = fetch_live;
  assign mem_a_addr   = fetch_live ? a_base_q + ADDR_W'(elem_idx) : '0;
  assign mem_b_addr   = fetch_live ? b_base_q + ADDR_W'(elem_idx) : '0;

  assign busy         = (state != S_IDLE);
  assign dp_reset     = (state == S_IDLE) || (state == S_CLR);
  assign dp_read_now  = (state == S_ISSUE);
  assign result_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = (len == '0) ? S_DONE : S_CLR;
      S_CLR:      if (cnt == CNT_W'(RST_CYCLES - 1)) state_nx = S_FETCH;
      S_FETCH:    if (fetch_last) state_nx = S_ISSUE;
      S_ISSUE:    state_nx = S_GAP;
      S_GAP:      if (cnt >= CNT_W'(PKT_GAP)) state_nx = more_pkts ? S_FETCH : S_WAIT_FIN;
      S_WAIT_FIN: if (dp_finish || wait_timeout) state_nx = S_DONE;
      S_DONE:     if (result_ready) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Shared cycle counter: CLR hold, fetch slot, cycles since strobe, WAIT_FIN timeout
  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (state == S_ISSUE)  cnt <= CNT_W'(1);
    else if (state_nx != state) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // Stage p0: remembers which slot was issued; memory data arrives during the next cycle
  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= fetch_issue;
  end

  always_ff @(posedge clk) begin
    slot_p0 <= cnt[SLOT_W-1:0];
    pad_p0  <= !fetch_live;
  end

  always_comb begin
    shadow_a_nx = shadow_a;
    shadow_b_nx = shadow_b;
    if (vld_p0) begin
      shadow_a_nx[(NI-1-int'(slot_p0))*ELEMENT_WIDTH +: ELEMENT_WIDTH] = pad_p0 ? '0 : mem_a_rdata;
      shadow_b_nx[(NI-1-int'(slot_p0))*ELEMENT_WIDTH +: ELEMENT_WIDTH] = pad_p0 ? '0 : mem_b_rdata;
    end
  end

  always_ff @(posedge clk) begin
    shadow_a <= shadow_a_nx;
    shadow_b <= shadow_b_nx;
  end

  // Job registers, engine-facing rows and the returned result
  always_ff @(posedge clk) begin
    if (reset) begin
      a_base_q      <= '0;
      b_base_q      <= '0;
      len_q         <= '0;
      pkt_base      <= '0;
      dp_first_row  <= '0;
      dp_second_row <= '0;
      result        <= '0;
      result_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_base_q   <= a_base;
          b_base_q   <= b_base;
          len_q      <= len;
          pkt_base   <= '0;
          result     <= '0;
          result_err <= 1'b0;
        end
        S_FETCH: if (fetch_last) begin
          // Include the final slot landing this very cycle
          dp_first_row  <= shadow_a_nx;
          dp_second_row <= shadow_b_nx;
        end
        S_ISSUE: pkt_base <= pkt_base + (LEN_W+1)'(NI);
        S_WAIT_FIN: begin
          if (dp_finish) begin
            result     <= dp_result;
            result_err <= 1'b0;
          end else if (wait_timeout) begin
            result     <= '0;
            result_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_dot_product_feeder.sv
// Directed bench for complex_dot_product_feeder with a 1-cycle-latency memory model and a
// minimal engine model whose finish/result are set per step.
module tb_complex_dot_product_feeder;

  localparam int W       = 64;
  localparam int NI      = 8;
  localparam int LEN_W   = 16;
  localparam int ADDR_W  = 16;
  localparam int PKT_GAP = 8;
  localparam int RST_CYC = 2;
  localparam int TIMEOUT = 1023;
  localparam logic [63:0] ONE = 64'h0000_0001_0000_0000;

  logic              clk = 1'b0;
  logic              reset, start, result_ready;
  logic [ADDR_W-1:0] a_base, b_base;
  logic [LEN_W-1:0]  len;
  logic              busy, mem_a_en, mem_b_en, dp_reset, dp_read_now;
  logic [ADDR_W-1:0] mem_a_addr, mem_b_addr;
  logic [W-1:0]      mem_a_rdata = '0, mem_b_rdata = '0;
  logic [W*NI-1:0]   dp_first_row, dp_second_row;
  logic              dp_finish = 1'b0;
  logic [W-1:0]      dp_result, result;
  logic              result_err, result_valid;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  int          fin_target = 0;
  logic [63:0] fin_val = '0;
  int          eng_strobes = 0, strobe_total = 0;
  int          en_a_cnt = 0, en_b_cnt = 0, bad_a = 0, bad_b = 0;
  int          lo_a = 0, hi_a = 65536, lo_b = 0, hi_b = 65536;

  always #5 clk = ~clk;

  assign dp_result = fin_val;

  complex_dot_product_feeder #(
    .ELEMENT_WIDTH(W), .NI(NI), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
    .PKT_GAP(PKT_GAP), .RST_CYCLES(RST_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .a_base(a_base), .b_base(b_base), .len(len),
    .busy(busy),
    .mem_a_en(mem_a_en), .mem_a_addr(mem_a_addr), .mem_a_rdata(mem_a_rdata),
    .mem_b_en(mem_b_en), .mem_b_addr(mem_b_addr), .mem_b_rdata(mem_b_rdata),
    .dp_reset(dp_reset), .dp_read_now(dp_read_now),
    .dp_first_row(dp_first_row), .dp_second_row(dp_second_row),
    .dp_finish(dp_finish), .dp_result(dp_result),
    .result(result), .result_err(result_err), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  // Memory model and activity monitor
  always @(posedge clk) begin
    if (mem_a_en) begin
      mem_a_rdata <= mem_a[mem_a_addr[7:0]];
      en_a_cnt    <= en_a_cnt + 1;
      if (int'(mem_a_addr) < lo_a || int'(mem_a_addr) >= hi_a) bad_a <= bad_a + 1;
    end
    if (mem_b_en) begin
      mem_b_rdata <= mem_b[mem_b_addr[7:0]];
      en_b_cnt    <= en_b_cnt + 1;
      if (int'(mem_b_addr) < lo_b || int'(mem_b_addr) >= hi_b) bad_b <= bad_b + 1;
    end
    if (dp_read_now) strobe_total <= strobe_total + 1;
  end

  // Engine model: finish rises after fin_target strobes (0 = never)
  always @(posedge clk) begin
    if (dp_reset) begin
      eng_strobes <= 0;
      dp_finish   <= 1'b0;
    end else begin
      if (dp_read_now) eng_strobes <= eng_strobes + 1;
      if (fin_target != 0 && eng_strobes >= fin_target) dp_finish <= 1'b1;
    end
  end

  function automatic logic [63:0] pa(input int j);
    logic [7:0] b;
    b = j[7:0];
    return {16'hA000, 8'h00, b, 32'h0000_0000};
  endfunction

  function automatic logic [63:0] pb(input int j);
    logic [7:0] b;
    b = j[7:0];
    return {16'hB000, 8'h00, b, 24'h00_0000, b};
  endfunction

  function automatic logic [63:0] slot_a(input int s);
    return dp_first_row[(NI-1-s)*W +: W];
  endfunction

  function automatic logic [63:0] slot_b(input int s);
    return dp_second_row[(NI-1-s)*W +: W];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_sig(input int which, input int bound, input string tag, output int k);
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < bound) begin
      @(negedge clk);
      k++;
      case (which)
        0:       hit = dp_read_now;
        1:       hit = result_valid;
        default: hit = mem_a_en;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $error("FAIL %s: got no event within %0d cycles, expected event", tag, bound);
    end
  endtask

  task automatic start_job(input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] ln);
    a_base = ab;
    b_base = bb;
    len    = ln;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_busy"},   busy, 1'b0);
    check({t, "_dprst"},  dp_reset, 1'b1);
    check({t, "_aen"},    mem_a_en, 1'b0);
    check({t, "_ben"},    mem_b_en, 1'b0);
    check({t, "_aaddr"},  mem_a_addr, '0);
    check({t, "_baddr"},  mem_b_addr, '0);
    check({t, "_strobe"}, dp_read_now, 1'b0);
    check({t, "_valid"},  result_valid, 1'b0);
    check({t, "_err"},    result_err, 1'b0);
    check({t, "_result"}, result, '0);
    check({t, "_rowa0"},  (dp_first_row == '0), 1'b1);
    check({t, "_rowb0"},  (dp_second_row == '0), 1'b1);
  endtask

  initial begin
    int k, d, s0, ea0, eb0;
    logic [63:0] e;
    for (int j = 0; j < 256; j++) begin
      mem_a[j] = pa(j);
      mem_b[j] = pb(j);
    end
    for (int j = 0; j < 8; j++) begin
      mem_a[16+j] = ONE;
      mem_b[64+j] = ONE;
    end
    reset = 1'b1; start = 1'b0; result_ready = 1'b0;
    a_base = '0; b_base = '0; len = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // len=8, all (1+0j): one package, engine returns 8
    lo_a = 16; hi_a = 24; lo_b = 64; hi_b = 72;
    fin_target = 1; fin_val = 64'h0000_0008_0000_0000;
    s0 = strobe_total; ea0 = en_a_cnt; eb0 = en_b_cnt;
    start_job(16'h0010, 16'h0040, 16'd8);
    check("t1_busy", busy, 1'b1);
    wait_sig(0, 40, "t1_strobe", k);
    check("t1_latency", 64'(k + 1), 64'd12);
    for (int s = 0; s < NI; s++) begin
      check($sformatf("t1_rowa_s%0d", s), slot_a(s), ONE);
      check($sformatf("t1_rowb_s%0d", s), slot_b(s), ONE);
    end
    wait_sig(1, 100, "t1_valid", k);
    check("t1_result", result, 64'h0000_0008_0000_0000);
    check("t1_err", result_err, 1'b0);
    check("t1_busy_done", busy, 1'b1);
    check("t1_strobes", 64'(strobe_total - s0), 64'd1);
    check("t1_en_a", 64'(en_a_cnt - ea0), 64'd8);
    check("t1_en_b", 64'(en_b_cnt - eb0), 64'd8);
    handshake();
    check("t1_busy_after", busy, 1'b0);
    check("t1_valid_after", result_valid, 1'b0);
    check("t1_dprst_after", dp_reset, 1'b1);

    // len=13: two packages, second one zero-padded in slots 5..7
    lo_a = 32; hi_a = 45; lo_b = 96; hi_b = 109;
    fin_target = 2; fin_val = 64'h0000_1234_FFFF_FFFE;
    s0 = strobe_total; ea0 = en_a_cnt; eb0 = en_b_cnt;
    start_job(16'h0020, 16'h0060, 16'd13);
    wait_sig(0, 40, "t2_strobe1", k);
    check("t2_latency", 64'(k + 1), 64'd12);
    for (int s = 0; s < NI; s++) begin
      check($sformatf("t2_p0_rowa_s%0d", s), slot_a(s), pa(32 + s));
      check($sformatf("t2_p0_rowb_s%0d", s), slot_b(s), pb(96 + s));
    end
    wait_sig(0, 60, "t2_strobe2", d);
    check("t2_gap_ok", (d >= PKT_GAP), 1'b1);
    for (int s = 0; s < NI; s++) begin
      e = (8 + s < 13) ? pa(32 + 8 + s) : 64'h0;
      check($sformatf("t2_p1_rowa_s%0d", s), slot_a(s), e);
      e = (8 + s < 13) ? pb(96 + 8 + s) : 64'h0;
      check($sformatf("t2_p1_rowb_s%0d", s), slot_b(s), e);
    end
    wait_sig(1, 100, "t2_valid", k);
    check("t2_result", result, 64'h0000_1234_FFFF_FFFE);
    check("t2_err", result_err, 1'b0);
    check("t2_strobes", 64'(strobe_total - s0), 64'd2);
    check("t2_en_a", 64'(en_a_cnt - ea0), 64'd13);
    check("t2_en_b", 64'(en_b_cnt - eb0), 64'd13);
    check("t2_bad_a", 64'(bad_a), 64'd0);
    check("t2_bad_b", 64'(bad_b), 64'd0);
    handshake();

    // len=0: immediate zero result, no memory or engine activity
    s0 = strobe_total; ea0 = en_a_cnt; eb0 = en_b_cnt;
    start_job(16'h0100, 16'h0200, 16'd0);
    check("t3_valid", result_valid, 1'b1);
    check("t3_result", result, 64'h0);
    check("t3_err", result_err, 1'b0);
    @(negedge clk);
    check("t3_valid_held", result_valid, 1'b1);
    check("t3_strobes", 64'(strobe_total - s0), 64'd0);
    check("t3_en_a", 64'(en_a_cnt - ea0), 64'd0);
    check("t3_en_b", 64'(en_b_cnt - eb0), 64'd0);
    handshake();
    check("t3_busy_after", busy, 1'b0);

    // Engine never finishes: timeout abort, then ready withheld for 20 cycles
    lo_a = 16; hi_a = 24; lo_b = 64; hi_b = 72;
    fin_target = 0; fin_val = 64'hDEAD_BEEF_DEAD_BEEF;
    start_job(16'h0010, 16'h0040, 16'd8);
    wait_sig(0, 40, "t4_strobe", k);
    wait_sig(1, 1200, "t4_valid", d);
    check("t4_timeout_window",
          ((k + 1 + d) >= 12 + TIMEOUT) && ((k + 1 + d) <= 12 + TIMEOUT + PKT_GAP + 4), 1'b1);
    check("t4_err", result_err, 1'b1);
    check("t4_result", result, 64'h0);
    ea0 = en_a_cnt;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      len   = '0;
      @(negedge clk);
      check($sformatf("t4_hold_valid_%0d", i), result_valid, 1'b1);
      check($sformatf("t4_hold_err_%0d", i), result_err, 1'b1);
    end
    start = 1'b0;
    check("t4_hold_busy", busy, 1'b1);
    check("t4_hold_en", 64'(en_a_cnt - ea0), 64'd0);
    handshake();
    check("t4_busy_after", busy, 1'b0);
    @(negedge clk);
    check("t4_no_queue_busy", busy, 1'b0);
    check("t4_no_queue_valid", result_valid, 1'b0);

    // Reset during package-2 fetch, then a clean job with A addresses wrapping past 0xFFFF
    lo_a = 32; hi_a = 45; lo_b = 96; hi_b = 109;
    fin_target = 0;
    start_job(16'h0020, 16'h0060, 16'd13);
    wait_sig(0, 40, "t5_strobe1", k);
    wait_sig(2, 40, "t5_fetch2", k);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_result", result_valid, 1'b0);
    check("t5_idle", busy, 1'b0);

    lo_a = 0; hi_a = 65536; lo_b = 64; hi_b = 72;
    fin_target = 1; fin_val = 64'h0000_0005_0000_0003;
    start_job(16'hFFFC, 16'h0040, 16'd8);
    wait_sig(0, 40, "t6_strobe", k);
    check("t6_latency", 64'(k + 1), 64'd12);
    check("t6_rowa_s0", slot_a(0), pa(8'hFC));
    check("t6_rowa_s3", slot_a(3), pa(8'hFF));
    check("t6_rowa_s4", slot_a(4), pa(8'h00));
    check("t6_rowa_s7", slot_a(7), pa(8'h03));
    check("t6_rowb_s3", slot_b(3), ONE);
    wait_sig(1, 100, "t6_valid", k);
    check("t6_result", result, 64'h0000_0005_0000_0003);
    check("t6_err", result_err, 1'b0);
    check("t6_bad_b", 64'(bad_b), 64'd0);
    handshake();
    check("t6_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
